regbank_wr_arbiter: RTL and testbench

//   Round-robin write arbiter for a bank of enable-controlled registers.

---
 rtl/regbank_wr_arbiter.sv | 115 +++++++++++
 tb/tb_regbank_wr_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regbank_wr_arbiter.sv
// Round-robin write arbiter driving the en/d pins of a register bank.
// One winner per cycle; the granted requester is masked for the following
// arbitration so a held req is treated as a fresh request one cycle later.
module regbank_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic [DEPTH-1:0]      reg_en,
    output logic [WIDTH-1:0]      reg_d,
    output logic                  err,
    output logic [7:0]            wr_count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [DEPTH-1:0] reg_en_q, reg_en_d;
    logic [WIDTH-1:0] reg_d_q, reg_d_d;
    logic             err_q, err_d;
    logic [7:0]       wr_count_q, wr_count_d;
    logic [PW-1:0]    ptr_q, ptr_d;

    logic [NREQ-1:0]  elig;
    logic             win_vld;
    logic [PW-1:0]    win;
    logic [AW-1:0]    win_addr;
    logic [WIDTH-1:0] win_data;
    logic             in_range;

    // Rotating priority search starting at ptr over the eligible requesters
    always_comb begin
        int idx;
        idx     = 0;
        elig    = req & ~gnt_q & {NREQ{~hold}};
        win_vld = 1'b0;
        win     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_vld && elig[PW'(idx)]) begin
                win_vld = 1'b1;
                win     = PW'(idx);
            end
        end
    end

    // Select the winner's address and data with constant part-selects
    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                win_addr = req_addr[i*AW +: AW];
                win_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state for grant, bank write port, error pulse, counter and pointer
    always_comb begin
        in_range   = int'(win_addr) < DEPTH;
        gnt_d      = '0;
        reg_en_d   = '0;
        reg_d_d    = reg_d_q;
        err_d      = 1'b0;
        wr_count_d = wr_count_q;
        ptr_d      = ptr_q;
        if (win_vld) begin
            gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win;
            reg_d_d = win_data;
            ptr_d   = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
            if (in_range) begin
                reg_en_d = {{(DEPTH-1){1'b0}}, 1'b1} << win_addr;
                if (wr_count_q != 8'hFF) wr_count_d = wr_count_q + 8'd1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // State registers; reset clears every output including the data register
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q      <= '0;
            reg_en_q   <= '0;
            reg_d_q    <= '0;
            err_q      <= 1'b0;
            wr_count_q <= '0;
            ptr_q      <= '0;
        end else begin
            gnt_q      <= gnt_d;
            reg_en_q   <= reg_en_d;
            reg_d_q    <= reg_d_d;
            err_q      <= err_d;
            wr_count_q <= wr_count_d;
            ptr_q      <= ptr_d;
        end
    end

    assign gnt      = gnt_q;
    assign reg_en   = reg_en_q;
    assign reg_d    = reg_d_q;
    assign err      = err_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Bench for regbank_wr_arbiter: two instances (DEPTH 8 and DEPTH 6) share the
// same stimulus; a reference model pushes expected outputs into per-instance
// queues at each edge and a monitor pops and compares on the falling edge.
module tb_regbank_wr_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 3;
    localparam int W    = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 hold;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*W-1:0]    req_data;

    logic [NREQ-1:0] gnt_a, gnt_b;
    logic [7:0]      en_a;
    logic [5:0]      en_b;
    logic [W-1:0]    d_a, d_b;
    logic            err_a, err_b;
    logic [7:0]      cnt_a, cnt_b;

    int nvec = 0;
    int nerr = 0;

    always #20 clk = ~clk;

    regbank_wr_arbiter #(.NREQ(NREQ), .DEPTH(8), .AW(AW), .WIDTH(W)) u_a (
        .clk(clk), .rst(rst), .hold(hold), .req(req), .req_addr(req_addr),
        .req_data(req_data), .gnt(gnt_a), .reg_en(en_a), .reg_d(d_a),
        .err(err_a), .wr_count(cnt_a));

    regbank_wr_arbiter #(.NREQ(NREQ), .DEPTH(6), .AW(AW), .WIDTH(W)) u_b (
        .clk(clk), .rst(rst), .hold(hold), .req(req), .req_addr(req_addr),
        .req_data(req_data), .gnt(gnt_b), .reg_en(en_b), .reg_d(d_b),
        .err(err_b), .wr_count(cnt_b));

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] en;
        logic [7:0] d;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state, one slot per instance
    int   m_ptr[2];
    int   m_prev[2];
    int   m_cnt[2];
    logic [7:0] m_d[2];
    int   m_depth[2] = '{8, 6};

    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            exp_t e;
            int win;
            int a;
            e.gnt = 4'd0; e.en = 8'd0; e.err = 1'b0;
            if (rst) begin
                m_ptr[n] = 0; m_prev[n] = -1; m_cnt[n] = 0; m_d[n] = 8'd0;
            end else begin
                win = -1;
                if (!hold)
                    for (int k = 0; k < NREQ; k++) begin
                        int i;
                        i = (m_ptr[n] + k) % NREQ;
                        if (win < 0 && req[i] && i != m_prev[n]) win = i;
                    end
                if (win >= 0) begin
                    e.gnt = 4'd1 << win;
                    m_d[n] = req_data[win*W +: W];
                    m_ptr[n] = (win + 1) % NREQ;
                    a = int'(req_addr[win*AW +: AW]);
                    if (a < m_depth[n]) begin
                        e.en = 8'd1 << a;
                        if (m_cnt[n] < 255) m_cnt[n] = m_cnt[n] + 1;
                    end else begin
                        e.err = 1'b1;
                    end
                end
                m_prev[n] = win;
            end
            e.d = m_d[n];
            e.cnt = 8'(m_cnt[n]);
            if (n == 0) q_a.push_back(e); else q_b.push_back(e);
        end
    end

    // Monitor: compare every registered output once per cycle
    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            chk("a_gnt", 32'(gnt_a), 32'(e.gnt));
            chk("a_reg_en", 32'(en_a), 32'(e.en));
            chk("a_reg_d", 32'(d_a), 32'(e.d));
            chk("a_err", 32'(err_a), 32'(e.err));
            chk("a_wr_count", 32'(cnt_a), 32'(e.cnt));
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            chk("b_gnt", 32'(gnt_b), 32'(e.gnt));
            chk("b_reg_en", 32'(en_b), 32'(e.en[5:0]));
            chk("b_reg_d", 32'(d_b), 32'(e.d));
            chk("b_err", 32'(err_b), 32'(e.err));
            chk("b_wr_count", 32'(cnt_b), 32'(e.cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #5;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [W-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*W +: W]   = d;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; req = 4'hF;
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), 8'(8'h11 * (i + 1)));

        // Reset with all requesting
        tick();
        chk("rst_gnt", 32'(gnt_a), 32'h0);
        chk("rst_reg_en", 32'(en_a), 32'h0);
        chk("rst_reg_d", 32'(d_a), 32'h0);
        chk("rst_err", 32'(err_a), 32'h0);
        chk("rst_wr_count", 32'(cnt_a), 32'h0);

        // Round-robin with req held
        rst = 1'b0;
        tick(); chk("rr_gnt0", 32'(gnt_a), 32'h1); chk("rr_en0", 32'(en_a), 32'h01);
        chk("rr_d0", 32'(d_a), 32'h11);
        tick(); chk("rr_gnt1", 32'(gnt_a), 32'h2); chk("rr_en1", 32'(en_a), 32'h02);
        tick(); chk("rr_gnt2", 32'(gnt_a), 32'h4); chk("rr_en2", 32'(en_a), 32'h04);
        tick(); chk("rr_gnt3", 32'(gnt_a), 32'h8); chk("rr_en3", 32'(en_a), 32'h08);
        chk("rr_cnt", 32'(cnt_a), 32'd4);
        tick(); chk("rr_gnt4", 32'(gnt_a), 32'h1);

        // Hold for three edges, then resume at saved pointer
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("hold_gnt", 32'(gnt_a), 32'h0);
            chk("hold_en", 32'(en_a), 32'h0);
        end
        hold = 1'b0;
        tick(); chk("hold_resume", 32'(gnt_a), 32'h2);

        // Reset mid-stream while gnt=0010
        rst = 1'b1;
        tick(); chk("mid_rst_gnt", 32'(gnt_a), 32'h0); chk("mid_rst_cnt", 32'(cnt_a), 32'h0);
        rst = 1'b0;
        tick(); chk("mid_rst_next", 32'(gnt_a), 32'h1);

        // Single write after a fresh reset
        rst = 1'b1; tick();
        rst = 1'b0; req = 4'b0100; set_req(2, 3'd5, 8'hA5);
        tick();
        chk("sw_gnt", 32'(gnt_a), 32'h4);
        chk("sw_en", 32'(en_a), 32'h20);
        chk("sw_d", 32'(d_a), 32'hA5);
        chk("sw_cnt", 32'(cnt_a), 32'd1);
        req = 4'b0000;
        tick();

        // Out-of-range address on the DEPTH=6 instance
        req = 4'b0010; set_req(1, 3'd7, 8'h5A);
        tick();
        chk("oor_gnt", 32'(gnt_b), 32'h2);
        chk("oor_en", 32'(en_b), 32'h0);
        chk("oor_err", 32'(err_b), 32'h1);
        chk("oor_cnt", 32'(cnt_b), 32'd1);
        chk("inr_en", 32'(en_a), 32'h80);
        req = 4'b0000;
        tick();
        chk("oor_err_clr", 32'(err_b), 32'h0);

        // Random traffic: occasional reset early, then long run for saturation
        for (int c = 0; c < 700; c++) begin
            rst  = (c < 150) && ($urandom_range(0, 49) == 0);
            hold = ($urandom_range(0, 9) == 0);
            req  = 4'($urandom);
            for (int i = 0; i < NREQ; i++)
                set_req(i, 3'($urandom), 8'($urandom));
            tick();
        end
        rst = 1'b0; hold = 1'b0; req = 4'b0000;
        tick();
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q_a.size() + q_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
